fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Controller for the MIPS fetch stage. It owns the fetch stage's `PCsrc` and `brnchJmpAddr` inputs and a new `fetch_en` PC-update enable. It loads the reset vector after reset and arbitrates redirect requests from the decode stage (branch) and the execute stage (jump). It holds fetch during pipeline stalls and debug halts, and emits a flush pulse for wrong-path instructions. It sits between the `mips` top level and the `fetch` instance, replacing the constant drive of those signals.

## Interface
- `RESET_VEC`, 32'h0000_0000, address loaded into the PC in the first cycle after reset.
- `CNT_W`, 16, width of the redirect counter.
- `clk`  in  1  core clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `stall`  in  1  downstream not ready; PC must hold.
- `br_req`  in  1  decode-stage taken branch.
- `br_addr`  in  32  branch target.
- `jmp_req`  in  1  execute-stage jump/redirect (older instruction).
- `jmp_addr`  in  32  jump target.
- `halt_req`  in  1  debug halt request, level.
- `resume`  in  1  leave HALT, pulse.
- `PCsrc`  out  1  1 = fetch loads `brnchJmpAddr`; 0 = PC+4.
- `brnchJmpAddr`  out  32  redirect address, word-aligned.
- `fetch_en`  out  1  PC update enable.
- `flush`  out  1  squash the instruction currently in fetch.
- `misalign`  out  1  1-cycle pulse: applied target had nonzero bits [1:0].
- `state`  out  2  current FSM state.
- `redirect_cnt`  out  CNT_W  count of applied redirects, saturating.

## Operation
- FSM states:
  - BOOT=0: entered on reset; lasts 1 cycle. Drives `PCsrc`=1, `brnchJmpAddr`=RESET_VEC, `fetch_en`=1. Always goes to RUN.
  - RUN=1: `fetch_en`=1 unless `stall` is high.
  - STALL=2: entered when `stall` is high in RUN; `fetch_en`=0; returns to RUN on the first cycle `stall` is low.
  - HALT=3: `fetch_en`=0; leaves to RUN on `resume`.
- Redirect priority: `jmp_req` > `br_req`. When both are high, the branch is wrong-path and is discarded.
- Redirect application (RUN, no stall): next cycle `PCsrc`=1, `brnchJmpAddr`=target with bits[1:0] forced to 0, `flush`=1, `redirect_cnt`+1.
- `misalign` pulses in the same cycle as the redirect if the raw target had bits[1:0] != 0.
- Redirects during STALL are held in a pending register (valid bit + address):
  - First request is captured.
  - A later `jmp_req` overwrites a pending branch.
  - A later `br_req` never overwrites a pending jump.
  - Pending is applied on the first non-stall cycle. If a new `jmp_req` arrives in that same cycle, the new jump wins.
- `halt_req` in RUN/STALL: any pending redirect is applied first, then HALT is entered. HALT is checked after redirects; redirect requests arriving in HALT are dropped.
- `redirect_cnt` saturates at all-ones; it does not wrap.
- `rst_n` low at any time, including mid-stall or with a pending redirect, clears everything. The next state is BOOT.

## Timing
- All outputs are registered. Request-to-`PCsrc` latency is 1 cycle; `PCsrc` and `flush` are high for exactly 1 cycle per redirect.
- Reset values: `PCsrc`=0, `brnchJmpAddr`=0, `fetch_en`=0, `flush`=0, `misalign`=0, `state`=BOOT, `redirect_cnt`=0, pending valid=0.
- First cycle with `rst_n` high: BOOT outputs are visible. Second cycle: RUN.
- `stall` takes effect on `fetch_en` 1 cycle after assertion and releases 1 cycle after deassertion.
- `resume` must be a 1-cycle pulse. `resume` and `halt_req` high together in HALT: stay in HALT.

## Configuration
- `FETCH_SEQ_STEP_EN` defined:
  - Adds input `step` (1 bit).
  - A `step` pulse in HALT drives `fetch_en`=1 for exactly 1 cycle; the FSM stays in HALT.
  - `step` outside HALT is ignored.
- Undefined: no `step` port; HALT exits only via `resume`.

## Structure
- Package `fetch_seq_pkg` holds:
  - State encoding constants BOOT/RUN/STALL/HALT.
  - Default `RESET_VEC`.
  - Source-select constants SRC_NONE/SRC_BR/SRC_JMP.
- Sub-module `redirect_arb`: combinational priority select among `jmp_req`, `br_req` and the pending entry; also does alignment masking and misalign detection. The FSM, pending register and counter live in `fetch_sequencer`.

## Test plan
- Reset then release → cycle 1: `PCsrc`=1, `brnchJmpAddr`=RESET_VEC, `state`=0; cycle 2: `PCsrc`=0, `state`=1, `fetch_en`=1.
- `br_req`=1 and `jmp_req`=1 same cycle, `br_addr`=0x40, `jmp_addr`=0x80 → next cycle `brnchJmpAddr`=0x80, `flush`=1, `redirect_cnt`=1.
- `stall` for 3 cycles, `br_req`(0x100) in stall cycle 1, `jmp_req`(0x200) in stall cycle 2 → after `stall` falls: single redirect to 0x200, `fetch_en` back to 1.
- `jmp_addr`=0x103 in RUN → `brnchJmpAddr`=0x100, `misalign`=1 for one cycle.
- `halt_req` with pending redirect 0x300 → redirect to 0x300 applied, then `state`=3, `fetch_en`=0. With `FETCH_SEQ_STEP_EN`: `step` pulse → `fetch_en`=1 for one cycle. Then `resume` → `state`=1.
- `rst_n` low during STALL with a pending redirect → no redirect afterwards; BOOT reload of RESET_VEC; `redirect_cnt`=0.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// Shared constants for the MIPS fetch sequencer: FSM encoding, redirect sources, default reset vector.
package fetch_seq_pkg;

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] STALL = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_BR   = 2'd1;
  localparam logic [1:0] SRC_JMP  = 2'd2;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Request/response bundle between the pipeline and the fetch sequencer.
// Carries the optional step input when FETCH_SEQ_STEP_EN is defined.
interface fetch_sequencer_if #(parameter int CNT_W = 16);
  logic              stall;
  logic              br_req;
  logic [31:0]       br_addr;
  logic              jmp_req;
  logic [31:0]       jmp_addr;
  logic              halt_req;
  logic              resume;
`ifdef FETCH_SEQ_STEP_EN
  logic              step;
`endif
  logic              PCsrc;
  logic [31:0]       brnchJmpAddr;
  logic              fetch_en;
  logic              flush;
  logic              misalign;
  logic [1:0]        state;
  logic [CNT_W-1:0]  redirect_cnt;

  modport master (
`ifdef FETCH_SEQ_STEP_EN
    output step,
`endif
    output stall, br_req, br_addr, jmp_req, jmp_addr, halt_req, resume,
    input  PCsrc, brnchJmpAddr, fetch_en, flush, misalign, state, redirect_cnt
  );

  modport slave (
`ifdef FETCH_SEQ_STEP_EN
    input  step,
`endif
    input  stall, br_req, br_addr, jmp_req, jmp_addr, halt_req, resume,
    output PCsrc, brnchJmpAddr, fetch_en, flush, misalign, state, redirect_cnt
  );
endinterface

// File: rtl/redirect_arb.sv
// Combinational redirect select: new jump > pending entry > new branch,
// with word alignment of the chosen target and misalign detection.
module redirect_arb
  import fetch_seq_pkg::*;
(
  input  logic        jmp_req,
  input  logic [31:0] jmp_addr,
  input  logic        br_req,
  input  logic [31:0] br_addr,
  input  logic        pend_valid,
  input  logic        pend_jmp,
  input  logic [31:0] pend_addr,
  output logic [1:0]  sel_src,
  output logic [31:0] sel_addr,
  output logic        sel_misalign
);
  logic [31:0] raw_addr;

  always_comb begin
    sel_src  = SRC_NONE;
    raw_addr = 32'h0;
    if (jmp_req) begin
      sel_src  = SRC_JMP;
      raw_addr = jmp_addr;
    end else if (pend_valid) begin
      sel_src  = pend_jmp ? SRC_JMP : SRC_BR;
      raw_addr = pend_addr;
    end else if (br_req) begin
      sel_src  = SRC_BR;
      raw_addr = br_addr;
    end
  end

  assign sel_addr     = word_align(raw_addr);
  assign sel_misalign = |raw_addr[1:0];
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: boot vector load, branch/jump redirect arbitration, stall/halt hold.
// Optional single-step in HALT is enabled by defining FETCH_SEQ_STEP_EN.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
  parameter int          CNT_W     = 16
)(
  input  logic               clk,
  input  logic               rst_n,
  fetch_sequencer_if.slave   bus
);
  logic [1:0]       state_reg, state_next;
  logic             booted_reg;
  logic             pcsrc_reg, pcsrc_next;
  logic [31:0]      addr_reg, addr_next;
  logic             fetch_en_reg, fetch_en_next;
  logic             flush_reg, flush_next;
  logic             misalign_reg, misalign_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pend_valid_reg, pend_valid_next;
  logic             pend_jmp_reg, pend_jmp_next;
  logic [31:0]      pend_addr_reg, pend_addr_next;
  logic [1:0]       sel_src;
  logic [31:0]      sel_addr;
  logic             sel_misalign;
  logic             apply;
  logic             step_fetch;
  logic             step_in;

`ifdef FETCH_SEQ_STEP_EN
  assign step_in = bus.step;
`else
  assign step_in = 1'b0;
`endif

  redirect_arb u_arb (
    .jmp_req      (bus.jmp_req),
    .jmp_addr     (bus.jmp_addr),
    .br_req       (bus.br_req),
    .br_addr      (bus.br_addr),
    .pend_valid   (pend_valid_reg),
    .pend_jmp     (pend_jmp_reg),
    .pend_addr    (pend_addr_reg),
    .sel_src      (sel_src),
    .sel_addr     (sel_addr),
    .sel_misalign (sel_misalign)
  );

  always_comb begin
    state_next      = state_reg;
    pcsrc_next      = 1'b0;
    addr_next       = addr_reg;
    flush_next      = 1'b0;
    misalign_next   = 1'b0;
    cnt_next        = cnt_reg;
    pend_valid_next = pend_valid_reg;
    pend_jmp_next   = pend_jmp_reg;
    pend_addr_next  = pend_addr_reg;
    apply           = 1'b0;
    step_fetch      = 1'b0;
    case (state_reg)
      BOOT: begin
        // Reset leaves us in BOOT; the first live cycle presents the vector, the next moves on.
        if (!booted_reg) begin
          pcsrc_next = 1'b1;
          addr_next  = RESET_VEC;
        end else begin
          state_next = RUN;
        end
      end
      RUN, STALL: begin
        if (bus.stall) begin
          state_next = STALL;
          // A pending jump is never displaced; a pending branch yields to any jump.
          if (bus.jmp_req && !(pend_valid_reg && pend_jmp_reg)) begin
            pend_valid_next = 1'b1;
            pend_jmp_next   = 1'b1;
            pend_addr_next  = bus.jmp_addr;
          end else if (bus.br_req && !pend_valid_reg) begin
            pend_valid_next = 1'b1;
            pend_jmp_next   = 1'b0;
            pend_addr_next  = bus.br_addr;
          end
        end else begin
          state_next      = RUN;
          pend_valid_next = 1'b0;
          if (sel_src != SRC_NONE) begin
            apply = 1'b1;
          end else if (bus.halt_req) begin
            state_next = HALT;
          end
        end
      end
      default: begin
        if (bus.resume && !bus.halt_req) begin
          state_next = RUN;
        end else begin
          step_fetch = step_in;
        end
      end
    endcase
    if (apply) begin
      pcsrc_next    = 1'b1;
      addr_next     = sel_addr;
      flush_next    = 1'b1;
      misalign_next = sel_misalign;
      if (cnt_reg != '1) begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
    fetch_en_next = (state_reg == BOOT && !booted_reg) || (state_next == RUN) || step_fetch;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= BOOT;
      booted_reg     <= 1'b0;
      pcsrc_reg      <= 1'b0;
      addr_reg       <= 32'h0;
      fetch_en_reg   <= 1'b0;
      flush_reg      <= 1'b0;
      misalign_reg   <= 1'b0;
      cnt_reg        <= '0;
      pend_valid_reg <= 1'b0;
      pend_jmp_reg   <= 1'b0;
      pend_addr_reg  <= 32'h0;
    end else begin
      state_reg      <= state_next;
      booted_reg     <= 1'b1;
      pcsrc_reg      <= pcsrc_next;
      addr_reg       <= addr_next;
      fetch_en_reg   <= fetch_en_next;
      flush_reg      <= flush_next;
      misalign_reg   <= misalign_next;
      cnt_reg        <= cnt_next;
      pend_valid_reg <= pend_valid_next;
      pend_jmp_reg   <= pend_jmp_next;
      pend_addr_reg  <= pend_addr_next;
    end
  end

  assign bus.PCsrc        = pcsrc_reg;
  assign bus.brnchJmpAddr = addr_reg;
  assign bus.fetch_en     = fetch_en_reg;
  assign bus.flush        = flush_reg;
  assign bus.misalign     = misalign_reg;
  assign bus.state        = state_reg;
  assign bus.redirect_cnt = cnt_reg;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed table-driven bench for fetch_sequencer plus a counter saturation sequence.
module tb_fetch_sequencer;
  import fetch_seq_pkg::*;

  localparam logic [31:0] RV = 32'h0000_1000;
`ifdef FETCH_SEQ_STEP_EN
  localparam logic STEP_FEN = 1'b1;
`else
  localparam logic STEP_FEN = 1'b0;
`endif

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        br_req;
    logic [31:0] br_addr;
    logic        jmp_req;
    logic [31:0] jmp_addr;
    logic        halt_req;
    logic        resume;
    logic        step;
    logic        pcsrc;
    logic [31:0] addr;
    logic        fen;
    logic        flush;
    logic        mis;
    logic [1:0]  st;
    logic [3:0]  cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  fetch_sequencer_if #(.CNT_W(4)) bif ();

  fetch_sequencer #(.RESET_VEC(RV), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  function automatic vec_t v(
    input logic r, input logic s, input logic b, input logic [31:0] ba,
    input logic j, input logic [31:0] ja, input logic h, input logic rs, input logic stp,
    input logic pc, input logic [31:0] a, input logic fe, input logic fl, input logic mi,
    input logic [1:0] st, input logic [3:0] c);
    vec_t t;
    t.rst_n = r;   t.stall = s;  t.br_req = b;   t.br_addr = ba;
    t.jmp_req = j; t.jmp_addr = ja; t.halt_req = h; t.resume = rs; t.step = stp;
    t.pcsrc = pc;  t.addr = a;   t.fen = fe;     t.flush = fl;  t.mis = mi;
    t.st = st;     t.cnt = c;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    rst_n        = t.rst_n;
    bif.stall    = t.stall;
    bif.br_req   = t.br_req;
    bif.br_addr  = t.br_addr;
    bif.jmp_req  = t.jmp_req;
    bif.jmp_addr = t.jmp_addr;
    bif.halt_req = t.halt_req;
    bif.resume   = t.resume;
`ifdef FETCH_SEQ_STEP_EN
    bif.step     = t.step;
`endif
  endtask

  task automatic check_vec(input string name, input vec_t t);
    compared++;
    if (bif.PCsrc !== t.pcsrc || bif.brnchJmpAddr !== t.addr || bif.fetch_en !== t.fen ||
        bif.flush !== t.flush || bif.misalign !== t.mis || bif.state !== t.st ||
        bif.redirect_cnt !== t.cnt) begin
      mismatched++;
      $display("FAIL %s: got pcsrc=%0b addr=%h fen=%0b flush=%0b mis=%0b state=%0d cnt=%0d; want pcsrc=%0b addr=%h fen=%0b flush=%0b mis=%0b state=%0d cnt=%0d",
               name, bif.PCsrc, bif.brnchJmpAddr, bif.fetch_en, bif.flush, bif.misalign,
               bif.state, bif.redirect_cnt, t.pcsrc, t.addr, t.fen, t.flush, t.mis, t.st, t.cnt);
    end else begin
      $display("ok   %s: pcsrc=%0b addr=%h fen=%0b flush=%0b mis=%0b state=%0d cnt=%0d",
               name, bif.PCsrc, bif.brnchJmpAddr, bif.fetch_en, bif.flush, bif.misalign,
               bif.state, bif.redirect_cnt);
    end
  endtask

  initial begin
    vec_t e;
    //           rst st br baddr   jm jaddr   hl rs sp | pc addr    fe fl mi state  cnt
    tbl.push_back(v(0, 0, 0, 0,      0, 0,      0, 0, 0,  0, 32'h0,   0, 0, 0, BOOT,  0));
    tbl.push_back(v(0, 0, 0, 0,      0, 0,      0, 0, 0,  0, 32'h0,   0, 0, 0, BOOT,  0));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      0, 0, 0,  1, RV,      1, 0, 0, BOOT,  0));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      0, 0, 0,  0, RV,      1, 0, 0, RUN,   0));
    tbl.push_back(v(1, 0, 1, 'h40,   1, 'h80,   0, 0, 0,  1, 32'h80,  1, 1, 0, RUN,   1));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      0, 0, 0,  0, 32'h80,  1, 0, 0, RUN,   1));
    tbl.push_back(v(1, 1, 1, 'h100,  0, 0,      0, 0, 0,  0, 32'h80,  0, 0, 0, STALL, 1));
    tbl.push_back(v(1, 1, 0, 0,      1, 'h200,  0, 0, 0,  0, 32'h80,  0, 0, 0, STALL, 1));
    tbl.push_back(v(1, 1, 0, 0,      0, 0,      0, 0, 0,  0, 32'h80,  0, 0, 0, STALL, 1));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      0, 0, 0,  1, 32'h200, 1, 1, 0, RUN,   2));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      0, 0, 0,  0, 32'h200, 1, 0, 0, RUN,   2));
    tbl.push_back(v(1, 0, 0, 0,      1, 'h103,  0, 0, 0,  1, 32'h100, 1, 1, 1, RUN,   3));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      0, 0, 0,  0, 32'h100, 1, 0, 0, RUN,   3));
    tbl.push_back(v(1, 1, 1, 'h300,  0, 0,      0, 0, 0,  0, 32'h100, 0, 0, 0, STALL, 3));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      1, 0, 0,  1, 32'h300, 1, 1, 0, RUN,   4));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      1, 0, 0,  0, 32'h300, 0, 0, 0, HALT,  4));
    tbl.push_back(v(1, 0, 0, 0,      1, 'h400,  1, 0, 0,  0, 32'h300, 0, 0, 0, HALT,  4));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      0, 0, 1,  0, 32'h300, STEP_FEN, 0, 0, HALT, 4));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      0, 0, 0,  0, 32'h300, 0, 0, 0, HALT,  4));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      1, 1, 0,  0, 32'h300, 0, 0, 0, HALT,  4));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      0, 1, 0,  0, 32'h300, 1, 0, 0, RUN,   4));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      0, 0, 1,  0, 32'h300, 1, 0, 0, RUN,   4));
    tbl.push_back(v(1, 1, 0, 0,      1, 'h500,  0, 0, 0,  0, 32'h300, 0, 0, 0, STALL, 4));
    tbl.push_back(v(1, 0, 0, 0,      1, 'h600,  0, 0, 0,  1, 32'h600, 1, 1, 0, RUN,   5));
    tbl.push_back(v(1, 1, 0, 0,      1, 'h700,  0, 0, 0,  0, 32'h600, 0, 0, 0, STALL, 5));
    tbl.push_back(v(1, 1, 1, 'h800,  0, 0,      0, 0, 0,  0, 32'h600, 0, 0, 0, STALL, 5));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      0, 0, 0,  1, 32'h700, 1, 1, 0, RUN,   6));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      0, 0, 0,  0, 32'h700, 1, 0, 0, RUN,   6));
    tbl.push_back(v(1, 1, 1, 'h900,  0, 0,      0, 0, 0,  0, 32'h700, 0, 0, 0, STALL, 6));
    tbl.push_back(v(0, 1, 0, 0,      0, 0,      0, 0, 0,  0, 32'h0,   0, 0, 0, BOOT,  0));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      0, 0, 0,  1, RV,      1, 0, 0, BOOT,  0));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      0, 0, 0,  0, RV,      1, 0, 0, RUN,   0));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      0, 0, 0,  0, RV,      1, 0, 0, RUN,   0));
    tbl.push_back(v(1, 1, 0, 0,      0, 0,      0, 0, 0,  0, RV,      0, 0, 0, STALL, 0));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      0, 0, 0,  0, RV,      1, 0, 0, RUN,   0));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      1, 0, 0,  0, RV,      0, 0, 0, HALT,  0));
    tbl.push_back(v(1, 0, 0, 0,      0, 0,      0, 1, 0,  0, RV,      1, 0, 0, RUN,   0));

    drive(tbl[0]);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      check_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Back-to-back jumps: each applies, counter stops at all-ones.
    for (int k = 1; k <= 17; k++) begin
      e = v(1, 0, 0, 0, 1, 32'h40 * k + 32'h1, 0, 0, 0,
            1, 32'h40 * k, 1, 1, 1, RUN, (k < 15) ? k[3:0] : 4'hF);
      drive(e);
      @(posedge clk);
      #1;
      check_vec($sformatf("sat%0d", k), e);
    end
    e = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h440, 1, 0, 0, RUN, 4'hF);
    drive(e);
    @(posedge clk);
    #1;
    check_vec("sat_idle", e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
